// File: rtl/ervp_cache_access_frontend.sv
// Front end of the cache core controller: issues core accesses to the cache, buffers read responses
// under a credit limit and serialises region control commands behind all in-flight reads.
module ervp_cache_access_frontend #(
   parameter int BW_ADDR              = 32,
   parameter int BW_ACCESS            = 32,
   parameter int RESP_DEPTH           = 4,
   parameter int BW_CACHE_CONTROL_CMD = 2
) (
   input  logic                            clk,
   input  logic                            rstnn,
   input  logic                            clear,
   input  logic                            enable,
   output logic                            busy,
   output logic                            rqready,
   input  logic                            rqvalid,
   input  logic [BW_ADDR-1:0]              rqaddr,
   input  logic                            rqwrite,
   input  logic [BW_ACCESS/8-1:0]          rqwstrb,
   input  logic [BW_ACCESS-1:0]            rqwdata,
   input  logic                            ryready,
   output logic                            ryvalid,
   output logic [BW_ACCESS-1:0]            ryrdata,
   output logic                            creq_ready,
   input  logic                            creq_valid,
   input  logic [BW_CACHE_CONTROL_CMD-1:0] creq_command,
   input  logic [BW_ADDR-1:0]              creq_start,
   input  logic [BW_ADDR-1:0]              creq_last,
   input  logic                            control_ready,
   output logic                            control_valid,
   output logic [BW_CACHE_CONTROL_CMD-1:0] control_command,
   output logic [BW_ADDR-1:0]              control_region_start,
   output logic [BW_ADDR-1:0]              control_region_last,
   input  logic                            access_cqready,
   output logic                            access_cqvalid,
   output logic [BW_ADDR-1:0]              access_cqaddr,
   output logic                            access_cqwrite,
   output logic [BW_ACCESS/8-1:0]          access_cqwstrb,
   output logic [BW_ACCESS-1:0]            access_cqwdata,
   input  logic                            access_cyvalid,
   input  logic [BW_ACCESS-1:0]            access_cyrdata,
   output logic                            resp_overflow
);

   localparam int BW_CNT = $clog2(RESP_DEPTH) + 1;
   localparam int BW_PTR = $clog2(RESP_DEPTH);
   localparam logic [BW_CNT:0]   DEPTH_SUM  = (BW_CNT+1)'(RESP_DEPTH);
   localparam logic [BW_CNT-1:0] DEPTH_FULL = BW_CNT'(RESP_DEPTH);

   typedef enum logic [1:0] {S_RUN, S_DRAIN, S_CTRL} state_t;

   state_t               state, state_next;
   logic [BW_CNT-1:0]    outstanding, outstanding_next, fifo_count;
   logic [BW_CNT:0]      credit_sum;
   logic                 credit, go, rd_accept, creq_accept, push, pop, fifo_full;
   logic [BW_PTR-1:0]    wr_ptr, rd_ptr;
   logic [BW_ACCESS-1:0] fifo_mem [RESP_DEPTH];

   // Reads in flight plus buffered responses may never exceed the FIFO size
   assign credit_sum = {1'b0, outstanding} + {1'b0, fifo_count};
   assign credit     = credit_sum < DEPTH_SUM;
   assign fifo_full  = fifo_count == DEPTH_FULL;

   assign access_cqvalid = rqvalid & go;
   assign rqready        = access_cqready & go;
   assign access_cqaddr  = rqaddr;
   assign access_cqwrite = rqwrite;
   assign access_cqwstrb = rqwstrb;
   assign access_cqwdata = rqwdata;

   assign rd_accept   = access_cqvalid & access_cqready & ~rqwrite;
   assign creq_accept = creq_ready & creq_valid;
   assign push        = access_cyvalid & ~fifo_full;
   assign pop         = ryvalid & ryready;
   assign ryvalid     = fifo_count != '0;
   assign ryrdata     = fifo_mem[rd_ptr];
   assign busy        = (state != S_RUN) | (outstanding != '0) | (fifo_count != '0);

   always_comb begin
      outstanding_next = outstanding;
      if (rd_accept & ~access_cyvalid)
         outstanding_next = outstanding + 1'b1;
      else if (~rd_accept & access_cyvalid & (outstanding != '0))
         outstanding_next = outstanding - 1'b1;
   end

   always_comb begin
      state_next    = state;
      go            = 1'b0;
      creq_ready    = 1'b0;
      control_valid = 1'b0;
      case (state)
         S_RUN: begin
            go         = enable & ~creq_valid & (rqwrite | credit);
            creq_ready = enable;
            if (creq_valid & enable)
               state_next = S_DRAIN;
         end
         // Leave as soon as the last read response lands, not a cycle later
         S_DRAIN: begin
            if (outstanding_next == '0)
               state_next = S_CTRL;
         end
         S_CTRL: begin
            control_valid = 1'b1;
            if (control_ready)
               state_next = S_RUN;
         end
         default: state_next = S_RUN;
      endcase
   end

   always_ff @(posedge clk or negedge rstnn) begin
      if (!rstnn) begin
         state                <= S_RUN;
         outstanding          <= '0;
         fifo_count           <= '0;
         wr_ptr               <= '0;
         rd_ptr               <= '0;
         resp_overflow        <= 1'b0;
         control_command      <= '0;
         control_region_start <= '0;
         control_region_last  <= '0;
      end else if (clear) begin
         state                <= S_RUN;
         outstanding          <= '0;
         fifo_count           <= '0;
         wr_ptr               <= '0;
         rd_ptr               <= '0;
         resp_overflow        <= 1'b0;
         control_command      <= '0;
         control_region_start <= '0;
         control_region_last  <= '0;
      end else begin
         state       <= state_next;
         outstanding <= outstanding_next;
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + 1'b1;
            2'b01:   fifo_count <= fifo_count - 1'b1;
            default: fifo_count <= fifo_count;
         endcase
         if (access_cyvalid & fifo_full)
            resp_overflow <= 1'b1;
         if (creq_accept) begin
            control_command      <= creq_command;
            control_region_start <= creq_start;
            control_region_last  <= creq_last;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push)
         fifo_mem[wr_ptr] <= access_cyrdata;
   end

endmodule

// File: tb/tb_ervp_cache_access_frontend.sv
// Directed bench for ervp_cache_access_frontend: credit limit, response path, control serialisation,
// overflow and asynchronous reset.
module tb_ervp_cache_access_frontend;

   logic        clk = 1'b0;
   logic        rstnn, clear, enable, busy, rqready, rqvalid, rqwrite;
   logic [31:0] rqaddr, rqwdata, ryrdata;
   logic [3:0]  rqwstrb, access_cqwstrb;
   logic        ryready, ryvalid, creq_ready, creq_valid, control_ready, control_valid;
   logic [1:0]  creq_command, control_command;
   logic [31:0] creq_start, creq_last, control_region_start, control_region_last;
   logic        access_cqready, access_cqvalid, access_cqwrite, access_cyvalid, resp_overflow;
   logic [31:0] access_cqaddr, access_cqwdata, access_cyrdata;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   ervp_cache_access_frontend #(
      .BW_ADDR(32), .BW_ACCESS(32), .RESP_DEPTH(4), .BW_CACHE_CONTROL_CMD(2)
   ) dut (
      .clk(clk), .rstnn(rstnn), .clear(clear), .enable(enable), .busy(busy),
      .rqready(rqready), .rqvalid(rqvalid), .rqaddr(rqaddr), .rqwrite(rqwrite),
      .rqwstrb(rqwstrb), .rqwdata(rqwdata), .ryready(ryready), .ryvalid(ryvalid),
      .ryrdata(ryrdata), .creq_ready(creq_ready), .creq_valid(creq_valid),
      .creq_command(creq_command), .creq_start(creq_start), .creq_last(creq_last),
      .control_ready(control_ready), .control_valid(control_valid),
      .control_command(control_command), .control_region_start(control_region_start),
      .control_region_last(control_region_last), .access_cqready(access_cqready),
      .access_cqvalid(access_cqvalid), .access_cqaddr(access_cqaddr),
      .access_cqwrite(access_cqwrite), .access_cqwstrb(access_cqwstrb),
      .access_cqwdata(access_cqwdata), .access_cyvalid(access_cyvalid),
      .access_cyrdata(access_cyrdata), .resp_overflow(resp_overflow)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      clear = 1'b0; enable = 1'b1; rqvalid = 1'b0; rqaddr = '0; rqwrite = 1'b0;
      rqwstrb = 4'hF; rqwdata = '0; ryready = 1'b0; creq_valid = 1'b0;
      creq_command = '0; creq_start = '0; creq_last = '0; control_ready = 1'b0;
      access_cqready = 1'b1; access_cyvalid = 1'b0; access_cyrdata = '0;
   endtask

   task automatic test_reset();
      rstnn = 1'b1;
      idle_inputs();
      #2 rstnn = 1'b0;
      step();
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %0h want 0", busy); end
      n_checks++; if (ryvalid !== 1'b0) begin n_fail++; $display("FAIL rst_ryvalid: got %0h want 0", ryvalid); end
      n_checks++; if (control_valid !== 1'b0) begin n_fail++; $display("FAIL rst_control_valid: got %0h want 0", control_valid); end
      n_checks++; if (control_command !== 2'd0) begin n_fail++; $display("FAIL rst_control_command: got %0h want 0", control_command); end
      n_checks++; if (control_region_last !== 32'd0) begin n_fail++; $display("FAIL rst_region_last: got %0h want 0", control_region_last); end
      n_checks++; if (resp_overflow !== 1'b0) begin n_fail++; $display("FAIL rst_overflow: got %0h want 0", resp_overflow); end
      rstnn = 1'b1;
      step();
   endtask

   task automatic test_credit();
      for (int i = 0; i < 5; i++) begin
         step();
         rqvalid = 1'b1; rqwrite = 1'b0; rqaddr = 32'(i * 4);
         #1;
         n_checks++;
         if (rqready !== (i < 4)) begin n_fail++; $display("FAIL credit_rqready[%0d]: got %0h want %0h", i, rqready, (i < 4)); end
         n_checks++;
         if (access_cqvalid !== (i < 4)) begin n_fail++; $display("FAIL credit_cqvalid[%0d]: got %0h want %0h", i, access_cqvalid, (i < 4)); end
      end
      step();
      access_cyvalid = 1'b1; access_cyrdata = 32'hA0;
      #1;
      n_checks++; if (rqready !== 1'b0) begin n_fail++; $display("FAIL credit_resp_blocked: got %0h want 0", rqready); end
      step();
      access_cyvalid = 1'b0;
      #1;
      n_checks++; if (ryvalid !== 1'b1) begin n_fail++; $display("FAIL credit_ryvalid: got %0h want 1", ryvalid); end
      n_checks++; if (ryrdata !== 32'hA0) begin n_fail++; $display("FAIL credit_ryrdata: got %0h want a0", ryrdata); end
      n_checks++; if (rqready !== 1'b0) begin n_fail++; $display("FAIL credit_prepop_blocked: got %0h want 0", rqready); end
      ryready = 1'b1;
      step();
      ryready = 1'b0;
      #1;
      n_checks++; if (rqready !== 1'b1) begin n_fail++; $display("FAIL credit_after_pop: got %0h want 1", rqready); end
      for (int i = 0; i < 5; i++) begin
         step();
         rqvalid = 1'b0; ryready = 1'b1;
         access_cyvalid = (i < 4); access_cyrdata = 32'hB0 + 32'(i);
         #1;
         if (i > 0) begin
            n_checks++;
            if (ryrdata !== 32'hB0 + 32'(i - 1)) begin n_fail++; $display("FAIL credit_order[%0d]: got %0h want %0h", i, ryrdata, 32'hB0 + 32'(i - 1)); end
         end
      end
      step();
      ryready = 1'b0;
      #1;
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL credit_idle_busy: got %0h want 0", busy); end
   endtask

   task automatic test_write_read();
      step();
      rqvalid = 1'b1; rqwrite = 1'b1; rqaddr = 32'h100; rqwstrb = 4'h5; rqwdata = 32'h12345678;
      #1;
      n_checks++; if (access_cqvalid !== 1'b1) begin n_fail++; $display("FAIL wr_cqvalid: got %0h want 1", access_cqvalid); end
      n_checks++; if (access_cqaddr !== 32'h100) begin n_fail++; $display("FAIL wr_cqaddr: got %0h want 100", access_cqaddr); end
      n_checks++; if (access_cqwrite !== 1'b1) begin n_fail++; $display("FAIL wr_cqwrite: got %0h want 1", access_cqwrite); end
      n_checks++; if (access_cqwstrb !== 4'h5) begin n_fail++; $display("FAIL wr_cqwstrb: got %0h want 5", access_cqwstrb); end
      n_checks++; if (access_cqwdata !== 32'h12345678) begin n_fail++; $display("FAIL wr_cqwdata: got %0h want 12345678", access_cqwdata); end
      step();
      rqwrite = 1'b0; rqwstrb = 4'hF;
      #1;
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL wr_no_outstanding: got %0h want 0", busy); end
      step();
      rqvalid = 1'b0;
      #1;
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rd_outstanding: got %0h want 1", busy); end
      step();
      access_cyvalid = 1'b1; access_cyrdata = 32'hDEADBEEF;
      #1;
      n_checks++; if (ryvalid !== 1'b0) begin n_fail++; $display("FAIL rd_ryvalid_early: got %0h want 0", ryvalid); end
      step();
      access_cyvalid = 1'b0;
      #1;
      n_checks++; if (ryvalid !== 1'b1) begin n_fail++; $display("FAIL rd_ryvalid: got %0h want 1", ryvalid); end
      n_checks++; if (ryrdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_ryrdata: got %0h want deadbeef", ryrdata); end
      ryready = 1'b1;
      step();
      ryready = 1'b0;
      #1;
      n_checks++; if (ryvalid !== 1'b0) begin n_fail++; $display("FAIL rd_popped: got %0h want 0", ryvalid); end
   endtask

   task automatic test_control();
      step();
      rqvalid = 1'b1; rqwrite = 1'b0; rqaddr = 32'h200;
      step();
      step();
      rqvalid = 1'b0; creq_valid = 1'b1; creq_command = 2'd2; creq_start = 32'h0; creq_last = 32'hFFF;
      #1;
      n_checks++; if (creq_ready !== 1'b1) begin n_fail++; $display("FAIL ctl_creq_ready: got %0h want 1", creq_ready); end
      step();
      creq_valid = 1'b0; rqvalid = 1'b1;
      #1;
      n_checks++; if (creq_ready !== 1'b0) begin n_fail++; $display("FAIL ctl_creq_ready_drop: got %0h want 0", creq_ready); end
      n_checks++; if (access_cqvalid !== 1'b0) begin n_fail++; $display("FAIL ctl_drain_block: got %0h want 0", access_cqvalid); end
      for (int i = 0; i < 2; i++) begin
         step();
         access_cyvalid = 1'b1; access_cyrdata = 32'hC0 + 32'(i);
         #1;
         n_checks++; if (access_cqvalid !== 1'b0) begin n_fail++; $display("FAIL ctl_drain_cq[%0d]: got %0h want 0", i, access_cqvalid); end
         n_checks++; if (control_valid !== 1'b0) begin n_fail++; $display("FAIL ctl_early[%0d]: got %0h want 0", i, control_valid); end
      end
      step();
      access_cyvalid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (i == 3) control_ready = 1'b1;
         #1;
         n_checks++; if (control_valid !== 1'b1) begin n_fail++; $display("FAIL ctl_valid[%0d]: got %0h want 1", i, control_valid); end
         n_checks++; if (control_command !== 2'd2) begin n_fail++; $display("FAIL ctl_cmd[%0d]: got %0h want 2", i, control_command); end
         n_checks++; if (control_region_start !== 32'h0) begin n_fail++; $display("FAIL ctl_start[%0d]: got %0h want 0", i, control_region_start); end
         n_checks++; if (control_region_last !== 32'hFFF) begin n_fail++; $display("FAIL ctl_last[%0d]: got %0h want fff", i, control_region_last); end
         n_checks++; if (access_cqvalid !== 1'b0) begin n_fail++; $display("FAIL ctl_cq_block[%0d]: got %0h want 0", i, access_cqvalid); end
         if (i < 3) step();
      end
      step();
      control_ready = 1'b0;
      #1;
      n_checks++; if (control_valid !== 1'b0) begin n_fail++; $display("FAIL ctl_valid_drop: got %0h want 0", control_valid); end
      n_checks++; if (access_cqvalid !== 1'b1) begin n_fail++; $display("FAIL ctl_resume: got %0h want 1", access_cqvalid); end
      n_checks++; if (ryrdata !== 32'hC0) begin n_fail++; $display("FAIL ctl_fifo_head: got %0h want c0", ryrdata); end
      step();
      rqvalid = 1'b0; access_cyvalid = 1'b1; access_cyrdata = 32'hC2; ryready = 1'b1;
      step();
      access_cyvalid = 1'b0;
      for (int i = 0; i < 4; i++) step();
      ryready = 1'b0;
      #1;
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ctl_idle: got %0h want 0", busy); end
   endtask

   task automatic test_same_cycle();
      step();
      rqvalid = 1'b1; rqwrite = 1'b0; rqaddr = 32'h300;
      creq_valid = 1'b1; creq_command = 2'd1; creq_start = 32'h40; creq_last = 32'h7F;
      #1;
      n_checks++; if (access_cqvalid !== 1'b0) begin n_fail++; $display("FAIL same_cq_block: got %0h want 0", access_cqvalid); end
      n_checks++; if (rqready !== 1'b0) begin n_fail++; $display("FAIL same_rq_block: got %0h want 0", rqready); end
      n_checks++; if (creq_ready !== 1'b1) begin n_fail++; $display("FAIL same_creq_ready: got %0h want 1", creq_ready); end
      step();
      creq_valid = 1'b0;
      #1;
      n_checks++; if (access_cqvalid !== 1'b0) begin n_fail++; $display("FAIL same_drain_cq: got %0h want 0", access_cqvalid); end
      step();
      control_ready = 1'b1;
      #1;
      n_checks++; if (control_valid !== 1'b1) begin n_fail++; $display("FAIL same_ctl_valid: got %0h want 1", control_valid); end
      n_checks++; if (control_region_start !== 32'h40) begin n_fail++; $display("FAIL same_ctl_start: got %0h want 40", control_region_start); end
      step();
      control_ready = 1'b0;
      #1;
      n_checks++; if (access_cqvalid !== 1'b1) begin n_fail++; $display("FAIL same_issue_after: got %0h want 1", access_cqvalid); end
      step();
      rqvalid = 1'b0; access_cyvalid = 1'b1; access_cyrdata = 32'hD0; ryready = 1'b1;
      step();
      access_cyvalid = 1'b0;
      for (int i = 0; i < 2; i++) step();
      ryready = 1'b0;
      #1;
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL same_idle: got %0h want 0", busy); end
   endtask

   task automatic test_overflow();
      step();
      rqvalid = 1'b1; rqwrite = 1'b0; rqaddr = 32'h400;
      step();
      access_cyvalid = 1'b1; access_cyrdata = 32'h11;
      #1;
      n_checks++; if (rqready !== 1'b1) begin n_fail++; $display("FAIL ovf_same_issue: got %0h want 1", rqready); end
      for (int i = 0; i < 3; i++) begin
         step();
         access_cyvalid = 1'b0;
         #1;
         n_checks++;
         if (rqready !== (i < 2)) begin n_fail++; $display("FAIL ovf_credit[%0d]: got %0h want %0h", i, rqready, (i < 2)); end
      end
      for (int i = 0; i < 3; i++) begin
         step();
         rqvalid = 1'b0; access_cyvalid = 1'b1; access_cyrdata = 32'h20 + 32'(i);
      end
      step();
      access_cyvalid = 1'b0;
      #1;
      n_checks++; if (resp_overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_none_yet: got %0h want 0", resp_overflow); end
      step();
      access_cyvalid = 1'b1; access_cyrdata = 32'hEE;
      step();
      access_cyvalid = 1'b0;
      #1;
      n_checks++; if (resp_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %0h want 1", resp_overflow); end
      step();
      n_checks++; if (resp_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %0h want 1", resp_overflow); end
      n_checks++; if (ryrdata !== 32'h11) begin n_fail++; $display("FAIL ovf_head: got %0h want 11", ryrdata); end
      clear = 1'b1;
      step();
      clear = 1'b0;
      #1;
      n_checks++; if (resp_overflow !== 1'b0) begin n_fail++; $display("FAIL clr_overflow: got %0h want 0", resp_overflow); end
      n_checks++; if (ryvalid !== 1'b0) begin n_fail++; $display("FAIL clr_ryvalid: got %0h want 0", ryvalid); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL clr_busy: got %0h want 0", busy); end
   endtask

   task automatic test_async_reset();
      step();
      rqvalid = 1'b1; rqwrite = 1'b0; rqaddr = 32'h500;
      step();
      step();
      rqvalid = 1'b0; access_cyvalid = 1'b1; access_cyrdata = 32'h33;
      step();
      access_cyvalid = 1'b0; creq_valid = 1'b1; creq_command = 2'd3; creq_last = 32'h1FF;
      step();
      creq_valid = 1'b0;
      #1;
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ar_busy_drain: got %0h want 1", busy); end
      n_checks++; if (ryvalid !== 1'b1) begin n_fail++; $display("FAIL ar_ryvalid_drain: got %0h want 1", ryvalid); end
      #2 rstnn = 1'b0;
      #1;
      n_checks++; if (control_valid !== 1'b0) begin n_fail++; $display("FAIL ar_control_valid: got %0h want 0", control_valid); end
      n_checks++; if (ryvalid !== 1'b0) begin n_fail++; $display("FAIL ar_ryvalid: got %0h want 0", ryvalid); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ar_busy: got %0h want 0", busy); end
      n_checks++; if (control_command !== 2'd0) begin n_fail++; $display("FAIL ar_command: got %0h want 0", control_command); end
      step();
      rstnn = 1'b1;
      step();
      rqvalid = 1'b1; rqaddr = 32'h600;
      #1;
      n_checks++; if (access_cqvalid !== 1'b1) begin n_fail++; $display("FAIL ar_read_issue: got %0h want 1", access_cqvalid); end
      step();
      rqvalid = 1'b0; access_cyvalid = 1'b1; access_cyrdata = 32'h55;
      step();
      access_cyvalid = 1'b0;
      #1;
      n_checks++; if (ryrdata !== 32'h55) begin n_fail++; $display("FAIL ar_read_data: got %0h want 55", ryrdata); end
      ryready = 1'b1;
      step();
      ryready = 1'b0;
      #1;
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ar_final_idle: got %0h want 0", busy); end
   endtask

   initial begin
      test_reset();
      test_credit();
      test_write_read();
      test_control();
      test_same_cycle();
      test_overflow();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
